// File: rtl/mic_spi_rx.sv
// Receiver for the Pmod MIC ADC serial stream: synchronizes ss/sck/miso into clk,
// assembles LEAD_BITS zero bits plus DATA_BITS of sample MSB first, and validates each frame.
`timescale 1ns/1ps

module mic_spi_rx #(
    parameter int DATA_BITS   = 12,
    parameter int LEAD_BITS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss,
    input  logic                 sck,
    input  logic                 miso,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int         WORD_BITS = LEAD_BITS + DATA_BITS;
    localparam logic [4:0] LAST_CNT  = 5'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] miso_sync_r;
    logic                   ss_prev_r;
    logic                   sck_prev_r;
    logic                   ss_s;
    logic                   sck_s;
    logic                   miso_s;
    logic                   ss_fall_s;
    logic                   ss_rise_s;
    logic                   sck_rise_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WORD_BITS-1:0]   shreg_r;
    logic [4:0]             cnt_r;
    logic                   clear_s;
    logic                   shift_s;
    logic                   accept_s;
    logic                   reject_s;

    // A frame is only trusted when every leading bit came back zero.
    function automatic logic lead_ok(input logic [WORD_BITS-1:0] word);
        return (word[WORD_BITS-1 -: LEAD_BITS] == {LEAD_BITS{1'b0}});
    endfunction

    // Equal-depth synchronizers keep ss, sck and miso aligned to the same clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_r   <= {SYNC_STAGES{1'b0}};
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            miso_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            miso_sync_r <= {miso_sync_r[SYNC_STAGES-2:0], miso};
        end
    end

    assign ss_s   = ss_sync_r[SYNC_STAGES-1];
    assign sck_s  = sck_sync_r[SYNC_STAGES-1];
    assign miso_s = miso_sync_r[SYNC_STAGES-1];

    // Previous-value copies for edge detection; cleared together with the synchronizers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_prev_r  <= 1'b0;
            sck_prev_r <= 1'b0;
        end else begin
            ss_prev_r  <= ss_s;
            sck_prev_r <= sck_s;
        end
    end

    // Both stages reset low, so ss held low through reset never looks like a fall.
    assign ss_fall_s  = ss_prev_r & ~ss_s;
    assign ss_rise_s  = ~ss_prev_r & ss_s;
    assign sck_rise_s = ~sck_prev_r & sck_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control; an sck rise outranks a simultaneous ss rise.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        shift_s     = 1'b0;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s = SHIFT;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (sck_rise_s) begin
                    shift_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else if (ss_rise_s) begin
                    reject_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (lead_ok(shreg_r)) begin
                    accept_s = 1'b1;
                end else begin
                    reject_s = 1'b1;
                end
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r      <= {WORD_BITS{1'b0}};
            cnt_r        <= 5'd0;
            sample       <= {DATA_BITS{1'b0}};
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= accept_s;
            frame_err    <= reject_s;
            busy         <= (state_nxt_s == SHIFT);
            if (clear_s) begin
                shreg_r <= {WORD_BITS{1'b0}};
                cnt_r   <= 5'd0;
            end else if (shift_s) begin
                shreg_r <= {shreg_r[WORD_BITS-2:0], miso_s};
                cnt_r   <= cnt_r + 5'd1;
            end else begin
                shreg_r <= shreg_r;
                cnt_r   <= cnt_r;
            end
            if (accept_s) begin
                sample <= shreg_r[DATA_BITS-1:0];
            end else begin
                sample <= sample;
            end
        end
    end

endmodule

// File: tb/tb_mic_spi_rx.sv
// Directed bench for mic_spi_rx: frames are bit-banged on ss/sck/miso asynchronously to clk
// and outputs are compared against hand-computed values.
`timescale 1ns/1ps

module tb_mic_spi_rx;

    localparam int CLK_H = 44;
    localparam int SCK_H = 709;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        ss   = 1'b1;
    logic        sck  = 1'b0;
    logic        miso = 1'b0;
    logic [11:0] sample;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    int total  = 0;
    int bad    = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    mic_spi_rx #(
        .DATA_BITS  (12),
        .LEAD_BITS  (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ss          (ss),
        .sck         (sck),
        .miso        (miso),
        .sample      (sample),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #CLK_H clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (sample_valid) n_valid++;
        if (frame_err) n_err++;
        if (sample_valid && frame_err) n_both++;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bits(input logic [15:0] w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            miso = w[15-i];
            #SCK_H;
            sck = 1'b1;
            #SCK_H;
            sck = 1'b0;
        end
    endtask

    // mode 0: normal close, 1: ss rises with the 16th sck rise, 2: three extra sck cycles
    task automatic frame(input logic [15:0] w, input int nbits, input int mode);
        ss = 1'b0;
        #SCK_H;
        if (mode == 1) begin
            bits(w, 0, 15);
            miso = w[0];
            #SCK_H;
            sck = 1'b1;
            ss  = 1'b1;
            #SCK_H;
            sck = 1'b0;
        end else begin
            bits(w, 0, nbits);
            if (mode == 2) bits(16'hFFFF, 0, 3);
            #SCK_H;
            ss = 1'b1;
        end
        #(2*SCK_H);
    endtask

    initial begin
        int          v0;
        int          e0;
        logic [3:0]  seen;
        logic [15:0] w;

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_sample", sample, 12'h000);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_no_pulses", n_valid + n_err, 0);

        // normal frame with exact latency check on the 16th sck rise
        v0 = n_valid; e0 = n_err;
        ss = 1'b0;
        #SCK_H;
        bits(16'h0A5C, 0, 8);
        #100;
        chk("busy_mid_frame", busy, 1'b1);
        bits(16'h0A5C, 8, 15);
        miso = 1'b0;
        #SCK_H;
        @(negedge clk);
        sck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen[k] = sample_valid;
        end
        chk("latency", seen, 4'b1000);
        #SCK_H;
        sck = 1'b0;
        #SCK_H;
        ss = 1'b1;
        #(2*SCK_H);
        chk("normal_valid_cnt", n_valid - v0, 1);
        chk("normal_err_cnt", n_err - e0, 0);
        chk("normal_sample", sample, 12'hA5C);
        chk("normal_busy_after", busy, 1'b0);

        // bad leading bits
        v0 = n_valid; e0 = n_err;
        frame(16'h4FFF, 16, 0);
        chk("badlead_err_cnt", n_err - e0, 1);
        chk("badlead_valid_cnt", n_valid - v0, 0);
        chk("badlead_sample", sample, 12'hA5C);

        // short frame then a good one
        v0 = n_valid; e0 = n_err;
        frame(16'h0FFF, 9, 0);
        chk("short_err_cnt", n_err - e0, 1);
        chk("short_valid_cnt", n_valid - v0, 0);
        chk("short_busy", busy, 1'b0);
        chk("short_sample", sample, 12'hA5C);
        v0 = n_valid; e0 = n_err;
        frame(16'h0321, 16, 0);
        chk("after_short_valid_cnt", n_valid - v0, 1);
        chk("after_short_err_cnt", n_err - e0, 0);
        chk("after_short_sample", sample, 12'h321);

        // reset after 7 bits; rest of that frame must be ignored
        v0 = n_valid; e0 = n_err;
        ss = 1'b0;
        #SCK_H;
        bits(16'h0456, 0, 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sample", sample, 12'h000);
        chk("midrst_valid", sample_valid, 1'b0);
        chk("midrst_err", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        bits(16'h0456, 7, 16);
        #SCK_H;
        ss = 1'b1;
        #(2*SCK_H);
        chk("midrst_no_valid", n_valid - v0, 0);
        chk("midrst_no_err", n_err - e0, 0);
        chk("midrst_sample_kept", sample, 12'h000);
        v0 = n_valid;
        frame(16'h0123, 16, 0);
        chk("after_rst_valid_cnt", n_valid - v0, 1);
        chk("after_rst_sample", sample, 12'h123);

        // ss rise coincident with the 16th sck rise
        v0 = n_valid; e0 = n_err;
        frame(16'h0BEE, 16, 1);
        chk("coinc_valid_cnt", n_valid - v0, 1);
        chk("coinc_err_cnt", n_err - e0, 0);
        chk("coinc_sample", sample, 12'hBEE);

        // extra sck cycles after the 16th bit
        v0 = n_valid; e0 = n_err;
        frame(16'h0777, 16, 2);
        chk("extra_valid_cnt", n_valid - v0, 1);
        chk("extra_err_cnt", n_err - e0, 0);
        chk("extra_sample", sample, 12'h777);

        // 100 back-to-back frames
        v0 = n_valid; e0 = n_err;
        for (int f = 0; f < 100; f++) begin
            w = {4'h0, 12'($urandom)};
            frame(w, 16, 0);
            chk("b2b_sample", sample, w[11:0]);
        end
        chk("b2b_valid_cnt", n_valid - v0, 100);
        chk("b2b_err_cnt", n_err - e0, 0);

        chk("never_both_high", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
